spi_mem_fsm: RTL and testbench
==============================

// Module: spi_mem_fsm
// PURPOSE
//  Transaction controller for the SPI memory datapath: sequences the 8-bit shift register,
//  address latch, data memory write and MISO tri-state buffer. Consumes conditioned CS and
//  SCLK edge pulses from inputconditioner instances; drives enables, never data.
//  One transaction per CS-low window: {addr[6:0], rw} byte, then 8 data bits in or out.
// PARAMETERS
//  ADDR_W       7     address bits preceding the R/W bit in the command byte
//  DATA_W       8     data bits per transaction
//  TIMEOUT_CYC  1024  clk cycles without an SCLK edge before abort (SPI_TIMEOUT_EN only)
// PORTS
//  clk           in   1  system clock; all state updates on posedge
//  reset         in   1  asynchronous, active-high; forces IDLE
//  cs            in   1  conditioned chip select, active low
//  sclk_posedge  in   1  one-clk pulse per SCLK rising edge
//  sclk_negedge  in   1  one-clk pulse per SCLK falling edge
//  rw_bit        in   1  shift register parallelDataOut[0]; 1=read, 0=write
//  addr_we       out  1  one-clk pulse: latch shift register into address latch
//  sr_we         out  1  one-clk pulse: parallel-load memory data into shift register
//  dm_we         out  1  one-clk pulse: write shift register contents to data memory
//  miso_buff     out  1  MISO tri-state enable, high for the whole read-shift phase
//  state         out  3  current state encoding (debug/LED mux)
//  timeout       out  1  one-clk pulse on watchdog abort; constant 0 without SPI_TIMEOUT_EN
// BEHAVIOUR
//  Reset: asynchronous, active-high; state=IDLE, bit counter=0, all outputs 0.
//  States (encoding): IDLE=0 GET_ADDR=1 GOT_ADDR=2 READ_LOAD=3 READ_SHIFT=4
//    WRITE_GET=5 WRITE_COMMIT=6 DONE=7. Outputs are Moore, decoded from registered state.
//  IDLE: cs==0 -> GET_ADDR, counter cleared.
//  GET_ADDR: counter +1 per sclk_posedge; when counter reaches ADDR_W+1 -> GOT_ADDR.
//  GOT_ADDR (1 clk, addr_we=1): rw_bit==1 -> READ_LOAD; else -> WRITE_GET, counter cleared.
//  READ_LOAD (1 clk, sr_we=1): -> READ_SHIFT, counter cleared.
//  READ_SHIFT (miso_buff=1): counter +1 per sclk_negedge; at DATA_W -> DONE.
//  WRITE_GET: counter +1 per sclk_posedge; at DATA_W -> WRITE_COMMIT.
//  WRITE_COMMIT (1 clk, dm_we=1): -> DONE.
//  DONE: all enables 0; waits for cs==1.
//  cs==1 in any state -> IDLE on next clk, priority over every edge pulse and counter
//    terminal count in the same cycle; no enable pulse is emitted on that cycle.
//  Counter width $clog2(max(ADDR_W+1,DATA_W)+1); never wraps, cleared on every phase entry.
//  Edge pulses in IDLE, GOT_ADDR, READ_LOAD, WRITE_COMMIT, DONE are ignored.
//  sclk_posedge and sclk_negedge asserted together: only the one relevant to the state counts.
//  Latency: addr_we one clk after the cycle carrying the (ADDR_W+1)th posedge; sr_we the clk
//    after addr_we; dm_we one clk after the cycle carrying the DATA_W-th data posedge.
//  Reset mid-transaction: immediate IDLE; host must re-assert CS for a new transaction.
// CONFIGURATION
//  SPI_TIMEOUT_EN defined: idle counter cleared on any sclk edge or state change; counts clk
//    in GET_ADDR, READ_SHIFT, WRITE_GET; reaching TIMEOUT_CYC -> DONE, timeout=1 for one
//    clk, no dm_we issued. Counter width $clog2(TIMEOUT_CYC+1).
//  SPI_TIMEOUT_EN undefined: no watchdog logic; timeout tied 0; stalled transaction waits
//    indefinitely until cs==1 or reset.
// TESTING
//  Write: cs=0, 8 posedges with rw_bit=0 at 8th, 8 posedges -> addr_we 1 pulse, dm_we 1 pulse
//    exactly 1 clk after 16th posedge cycle, state=7; cs=1 -> state=0.
//  Read: cs=0, 8 posedges with rw_bit=1 -> addr_we then sr_we on consecutive clks; miso_buff
//    high until 8th negedge, then state=7, dm_we never asserted.
//  Abort: cs=0, 3 posedges, cs=1 -> state=0 next clk, no addr_we/sr_we/dm_we pulse.
//  Collision: cs=1 in same clk as 8th address posedge -> state=0, addr_we stays 0.
//  Async reset: reset pulse mid WRITE_GET (between clk edges) -> state=0, all outputs 0
//    before next posedge clk; later cs=0 starts clean GET_ADDR with counter=0.
//  Timeout (TIMEOUT_CYC=16): cs=0, 2 posedges, stall 16 clks -> timeout 1 pulse, state=7;
//    without SPI_TIMEOUT_EN state stays 1 indefinitely and timeout stays 0.

Source files
------------

// File: rtl/spi_mem_fsm.sv
// spi_mem_fsm: sequences the SPI memory datapath enables (address latch, shift-register load,
//   data memory write, MISO tri-state) for one {addr,rw} command byte plus DATA_W data bits.
// Latency: Moore outputs; each phase ends one clk after the cycle carrying its last SCLK pulse.
// Backpressure: none; SCLK edge pulses are consumed as they arrive, cs high aborts on next clk.
// Optional watchdog: define SPI_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYC clks.
module spi_mem_fsm #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       rw_bit,
  output logic       addr_we,
  output logic       sr_we,
  output logic       dm_we,
  output logic       miso_buff,
  output logic [2:0] state,
  output logic       timeout
);

  localparam int CMD_BITS = ADDR_W + 1;
  localparam int MAX_CNT  = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
  localparam int CNT_W    = $clog2(MAX_CNT + 1);

  // Terminal values are one below the bit count: the phase ends in the cycle carrying the
  // last pulse, so the counter itself never has to hold the full count.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GOT_ADDR     = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_GET    = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wd_fire;

`ifdef SPI_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_counting;

  // Watchdog: counts quiet clks in the SCLK-driven phases. No two counting states are
  // adjacent, so clearing outside them also covers the clear-on-state-change rule.
  always_comb begin
    wd_d        = '0;
    wd_fire     = 1'b0;
    wd_counting = (state_q == GET_ADDR) || (state_q == READ_SHIFT) || (state_q == WRITE_GET);
    if (wd_counting && !sclk_posedge && !sclk_negedge) begin
      if (wd_q == WD_LAST) begin
        wd_fire = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    timeout_d = wd_fire && !cs;
  end

  // Watchdog counter and one-clk abort flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // State and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and bit counter; cs high overrides every edge, terminal count and timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!cs) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (sclk_posedge) begin
          if (cnt_q == ADDR_LAST) begin
            state_d = GOT_ADDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GOT_ADDR: begin
        cnt_d   = '0;
        state_d = rw_bit ? READ_LOAD : WRITE_GET;
      end
      READ_LOAD: begin
        cnt_d   = '0;
        state_d = READ_SHIFT;
      end
      READ_SHIFT: begin
        // Data is driven out on the falling edge, so only negedges advance this phase.
        if (sclk_negedge) begin
          if (cnt_q == DATA_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE_GET: begin
        if (sclk_posedge) begin
          if (cnt_q == DATA_LAST) begin
            state_d = WRITE_COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE_COMMIT: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (wd_fire) begin
      state_d = DONE;
      cnt_d   = '0;
    end

    if (cs) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    addr_we   = (state_q == GOT_ADDR);
    sr_we     = (state_q == READ_LOAD);
    dm_we     = (state_q == WRITE_COMMIT);
    miso_buff = (state_q == READ_SHIFT);
    state     = state_q;
  end

endmodule

// File: tb/tb_spi_mem_fsm.sv
// tb_spi_mem_fsm: self-checking bench for spi_mem_fsm.
// Observed vector per cycle is {state[2:0], addr_we, sr_we, dm_we, miso_buff, timeout}.
// Inputs change 1 time unit after posedge clk; outputs are sampled on negedge clk.
module tb_spi_mem_fsm;

  localparam int CMD_BITS = 8;
  localparam int DATA_BITS = 8;
  localparam int L = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       sclk_posedge;
  logic       sclk_negedge;
  logic       rw_bit;
  logic       addr_we;
  logic       sr_we;
  logic       dm_we;
  logic       miso_buff;
  logic [2:0] state;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  spi_mem_fsm #(
    .ADDR_W(7),
    .DATA_W(8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge),
    .rw_bit(rw_bit),
    .addr_we(addr_we),
    .sr_we(sr_we),
    .dm_we(dm_we),
    .miso_buff(miso_buff),
    .state(state),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       pos;
    logic       neg;
    logic       rw;
    logic [2:0] st;
    logic       aw;
    logic       sw;
    logic       dw;
    logic       mb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic p, logic n, logic r,
                              int st, logic aw, logic sw, logic dw, logic mb);
    vec_t v;
    v.cs = c; v.pos = p; v.neg = n; v.rw = r;
    v.st = 3'(st); v.aw = aw; v.sw = sw; v.dw = dw; v.mb = mb;
    return v;
  endfunction

  function automatic logic [7:0] obs_now();
    return {state, addr_we, sr_we, dm_we, miso_buff, timeout};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d aw/sw/dw/mb/to=%b want st=%0d aw/sw/dw/mb/to=%b",
               name, got[7:5], got[4:0], exp[7:5], exp[4:0]);
    end
  endtask

  // One clock cycle: drive inputs, sample at negedge, return to posedge+1.
  task automatic cyc(input logic c, input logic p, input logic n, input logic r,
                     output logic [7:0] o);
    cs = c; sclk_posedge = p; sclk_negedge = n; rw_bit = r;
    @(negedge clk);
    o = obs_now();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of a randomized transaction, from the cycle indices of the counted pulses:
  // c8 = cycle of the last command posedge, e8 = cycle of the last data pulse, a = cs rise cycle.
  function automatic logic [7:0] exp_rand(int c, int a, int c8, int e8, bit rd);
    int st = 0;
    bit aw = 0, sw = 0, dw = 0, mb = 0;
    if (c == 0 || c > a) st = 0;
    else if (c8 < 0 || c <= c8) st = 1;
    else if (c == c8 + 1) begin st = 2; aw = 1; end
    else if (rd) begin
      if (c == c8 + 2) begin st = 3; sw = 1; end
      else if (e8 < 0 || c <= e8) begin st = 4; mb = 1; end
      else st = 7;
    end else begin
      if (e8 < 0 || c <= e8) st = 5;
      else if (c == e8 + 1) begin st = 6; dw = 1; end
      else st = 7;
    end
    return {3'(st), aw, sw, dw, mb, 1'b0};
  endfunction

  logic [7:0] o;
  bit         pa[0:L-1];
  bit         na[0:L-1];
  int         a_cyc, c8, e8, k, quiet, start;
  bit         rd;

  initial begin
    // Write transaction, with pulses in GOT_ADDR and WRITE_COMMIT that must be ignored.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0, 0));
    for (int i = 10; i <= 17; i++) tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 6, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Read transaction, posedge and negedge together throughout.
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3, 0, 1, 0, 0));
    for (int i = 11; i <= 18; i++) tbl.push_back(mk(0, 1, 1, 1, 4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state.
    reset = 1'b1; cs = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; rw_bit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs_now(), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1, 1, 1, 1, o);
    check("idle_cs_high", o, 8'h00);

    // Table-driven write and read.
    foreach (tbl[i]) begin
      cyc(tbl[i].cs, tbl[i].pos, tbl[i].neg, tbl[i].rw, o);
      check($sformatf("tbl[%0d]", i), o,
            {tbl[i].st, tbl[i].aw, tbl[i].sw, tbl[i].dw, tbl[i].mb, 1'b0});
    end

    // Abort after 3 address posedges.
    cyc(0, 0, 0, 0, o); check("abort_c0", o, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0, 0, o); check($sformatf("abort_c%0d", i), o, {3'd1, 5'b0});
    end
    cyc(1, 0, 0, 0, o); check("abort_c4", o, {3'd1, 5'b0});
    cyc(1, 0, 0, 0, o); check("abort_c5", o, 8'h00);
    cyc(1, 0, 0, 0, o); check("abort_c6", o, 8'h00);

    // cs rises in the same cycle as the last command posedge.
    cyc(0, 0, 0, 0, o); check("coll_c0", o, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 1, 0, 0, o); check($sformatf("coll_c%0d", i), o, {3'd1, 5'b0});
    end
    cyc(1, 1, 0, 0, o); check("coll_c8", o, {3'd1, 5'b0});
    cyc(1, 0, 0, 0, o); check("coll_c9", o, 8'h00);
    cyc(1, 0, 0, 0, o); check("coll_c10", o, 8'h00);

    // Asynchronous reset in the middle of WRITE_GET.
    cyc(0, 0, 0, 0, o);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0, o);
    cyc(0, 0, 0, 0, o); check("arst_got", o, {3'd2, 5'b10000});
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, o);
    check("arst_pre", obs_now(), {3'd5, 5'b0});
    #2;
    reset = 1'b1;
    #1;
    check("arst_async", obs_now(), 8'h00);
    #1;
    reset = 1'b0; cs = 1'b1; sclk_posedge = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 1, o); check("arst_new_c0", o, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 1, o); check($sformatf("arst_new_c%0d", i), o, {3'd1, 5'b0});
    end
    cyc(1, 0, 0, 1, o); check("arst_new_c9", o, {3'd2, 5'b10000});
    cyc(1, 0, 0, 0, o); check("arst_new_c10", o, 8'h00);

    // Stall after 2 command posedges.
    cyc(0, 0, 0, 0, o); check("stall_c0", o, 8'h00);
    cyc(0, 1, 0, 0, o); check("stall_c1", o, {3'd1, 5'b0});
    cyc(0, 1, 0, 0, o); check("stall_c2", o, {3'd1, 5'b0});
    for (int c = 3; c <= 24; c++) begin
      cyc(0, 0, 0, 0, o);
`ifdef SPI_TIMEOUT_EN
      if (c <= 18) check($sformatf("stall_c%0d", c), o, {3'd1, 5'b0});
      else if (c == 19) check("stall_timeout", o, {3'd7, 5'b00001});
      else check($sformatf("stall_c%0d", c), o, {3'd7, 5'b0});
`else
      check($sformatf("stall_c%0d", c), o, {3'd1, 5'b0});
`endif
    end
    cyc(1, 0, 0, 0, o);
    cyc(1, 0, 0, 0, o); check("stall_end", o, 8'h00);

    // Randomized transactions against the pulse-index model.
    for (int t = 0; t < 40; t++) begin
      rd = 1'($urandom_range(0, 1));
      quiet = 0;
      for (int c = 0; c < L; c++) begin
        pa[c] = ($urandom_range(0, 2) == 0);
        na[c] = ($urandom_range(0, 2) == 0);
        if (quiet >= 3) pa[c] = 1'b1;
        quiet = (pa[c] || na[c]) ? 0 : quiet + 1;
      end
      a_cyc = ($urandom_range(0, 1) == 1) ? L - 1 : $urandom_range(1, L - 2);
      c8 = -1; k = 0;
      for (int c = 1; c < L && c8 < 0; c++) begin
        if (pa[c]) begin k++; if (k == CMD_BITS) c8 = c; end
      end
      e8 = -1; k = 0;
      if (c8 >= 0) begin
        start = rd ? c8 + 3 : c8 + 2;
        for (int c = start; c < L && e8 < 0; c++) begin
          if (rd ? na[c] : pa[c]) begin k++; if (k == DATA_BITS) e8 = c; end
        end
      end
      for (int c = 0; c <= a_cyc + 1; c++) begin
        cyc((c >= a_cyc), (c < L) ? pa[c] : 1'b0, (c < L) ? na[c] : 1'b0, rd, o);
        check($sformatf("rnd t%0d c%0d", t, c), o, exp_rand(c, a_cyc, c8, e8, rd));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
